// File: rtl/io_uart_port.sv
// io_uart_port: I/O-space 8N1 UART with one data and one status register, one side effect per bus cycle.
module io_uart_port #(
    parameter int          BAUD_DIV  = 434,
    parameter logic [15:0] BASE_ADDR = 16'h03F8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [23:1] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        wr,
    input  logic        low,
    input  logic        high,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          hit, acc, rd0, rd1, wr0, wr_ok;
    logic          hit_q;
    logic [7:0]    holding_q, holding_d;
    logic          tx_full_q, tx_full_d;
    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_load, tx_end;
    logic          txd_q, txd_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_end, rx_half, rx_done, rx_ok, rx_bad, rx_take;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic [15:0]   status, data_out_q, data_out_d;
    logic          irq_q;
    logic          unused_ok;

    assign unused_ok = ^{addr[23:16], data_in[15:8], high};

    assign hit   = cs && (addr[15:2] == BASE_ADDR[15:2]);
    assign acc   = hit && !hit_q;
    assign rd0   = acc && !wr && !addr[1];
    assign rd1   = acc && !wr && addr[1];
    assign wr0   = acc && wr && !addr[1] && low;
    // a write landing on the load cycle still fits: holding is being emptied
    assign wr_ok = wr0 && (!tx_full_q || tx_load);

    assign holding_d = wr_ok ? data_in[7:0] : holding_q;
    assign tx_full_d = wr_ok ? 1'b1 : tx_load ? 1'b0 : tx_full_q;
    assign tx_end    = tx_cnt_q == CW'(BAUD_DIV - 1);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_end ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (tx_full_q) begin
                    tx_load    = 1'b1;
                    tx_shift_d = holding_q;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_end) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_end) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 1'b1;
                tx_state_d = (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end
            default: if (tx_end) tx_state_d = S_IDLE;
        endcase
    end

    assign txd_d = (tx_state_d == S_START) ? 1'b0 : (tx_state_d == S_DATA) ? tx_shift_d[0] : 1'b1;

    assign rx_fall = rx_prev_q && !rx_s2_q;
    assign rx_end  = rx_cnt_q == CW'(BAUD_DIV - 1);
    assign rx_half = rx_cnt_q == CW'(BAUD_DIV / 2 - 1);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_fall ? S_START : S_IDLE;
            end
            S_START: if (rx_half) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_state_d = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end
            default: if (rx_end) begin
                rx_cnt_d   = '0;
                rx_done    = 1'b1;
                rx_state_d = S_IDLE;
            end
        endcase
    end

    // a data read in the completion cycle frees the buffer, so the new byte is not an overrun
    assign rx_ok      = rx_done && rx_s2_q;
    assign rx_bad     = rx_done && !rx_s2_q;
    assign rx_take    = rx_ok && (!rx_valid_q || rd0);
    assign rx_data_d  = rx_take ? rx_shift_q : rx_data_q;
    assign rx_valid_d = rx_ok || (rx_valid_q && !rd0);
    assign overrun_d  = (rx_ok && rx_valid_q && !rd0) || (overrun_q && !rd1);
    assign ferr_d     = rx_bad || (ferr_q && !rd1);

    assign status     = {12'h000, ferr_q, overrun_q, !tx_full_q, rx_valid_q};
    assign data_out_d = hit ? (addr[1] ? status : {8'h00, rx_data_q}) : data_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q      <= 1'b0;
            holding_q  <= '0;
            tx_full_q  <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            hit_q      <= hit;
            holding_q  <= holding_d;
            tx_full_q  <= tx_full_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            data_out_q <= data_out_d;
            irq_q      <= rx_valid_q;
        end
    end

    assign data_out = data_out_q;
    assign txd      = txd_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_io_uart_port.sv
// tb_io_uart_port: directed register/serial vectors for io_uart_port at 8 clocks per bit.
module tb_io_uart_port;
    localparam logic [15:0] BASE = 16'h03F8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic [23:1] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        wr = 1'b0;
    logic        low = 1'b0;
    logic        high = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic        irq;
        logic [15:0] st;
        logic [15:0] dat;
    } rx_vec_t;
    rx_vec_t vt[4];

    io_uart_port #(.BAUD_DIV(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data_in(data_in),
        .data_out(data_out), .wr(wr), .low(low), .high(high),
        .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic a1, input logic lo, input logic [15:0] d, input int n);
        cs = 1'b1;
        wr = w;
        addr = {8'h00, BASE[15:2], a1};
        data_in = d;
        low = lo;
        high = 1'b1;
        repeat (n) tick();
        cs = 1'b0;
        wr = 1'b0;
        tick();
    endtask

    task automatic rd(input logic a1, input logic [15:0] exp, input string nm);
        bus(1'b0, a1, 1'b0, 16'h0000, 1);
        chk(nm, data_out, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (8) tick();
        end
        rxd = stop;
        repeat (8) tick();
        rxd = 1'b1;
        repeat (2) tick();
    endtask

    // call at a falling edge; checks the idle gap before the start bit, then every cycle of the frame
    task automatic tx_expect(input logic [7:0] b, input int exp_gap);
        int gap = 0;
        int ok;
        logic e;
        while (txd === 1'b1 && gap < 300) begin
            gap++;
            @(negedge clk);
        end
        chk($sformatf("tx_%02h_gap", b), 16'(gap), 16'(exp_gap));
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            ok = 0;
            repeat (8) begin
                if (txd === e) ok++;
                @(negedge clk);
            end
            chk($sformatf("tx_%02h_bit%0d", b, k), 16'(ok), 16'd8);
        end
    endtask

    task automatic idle_check(input int n, input string nm);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk(nm, 16'(lows), 16'd0);
    endtask

    initial begin
        vt[0] = '{b: 8'h96, stop: 1'b1, irq: 1'b1, st: 16'h0003, dat: 16'h0096};
        vt[1] = '{b: 8'h00, stop: 1'b1, irq: 1'b1, st: 16'h0003, dat: 16'h0000};
        vt[2] = '{b: 8'hFF, stop: 1'b1, irq: 1'b1, st: 16'h0003, dat: 16'h00FF};
        vt[3] = '{b: 8'h5A, stop: 1'b0, irq: 1'b0, st: 16'h000A, dat: 16'h00FF};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_txd", {15'h0, txd}, 16'h0001);
        chk("rst_dout", data_out, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);
        rd(1'b1, 16'h0002, "rst_status");

        bus(1'b1, 1'b0, 1'b1, 16'h0055, 1);
        @(negedge clk);
        tx_expect(8'h55, 0);

        bus(1'b1, 1'b0, 1'b0, 16'h00AA, 1);
        bus(1'b1, 1'b1, 1'b1, 16'hFFFF, 1);
        idle_check(120, "tx_no_frame_low0_reg1");
        rd(1'b1, 16'h0002, "status_after_ignored");

        bus(1'b1, 1'b0, 1'b1, 16'h00A5, 1);
        fork
            begin
                @(negedge clk);
                tx_expect(8'hA5, 0);
                tx_expect(8'h3C, 1);
            end
            begin
                bus(1'b1, 1'b0, 1'b1, 16'h003C, 1);
                bus(1'b1, 1'b0, 1'b1, 16'h0077, 1);
                rd(1'b1, 16'h0000, "status_tx_full");
            end
        join
        idle_check(120, "tx_third_dropped");

        for (int i = 0; i < 4; i++) begin
            send_rx(vt[i].b, vt[i].stop);
            chk($sformatf("v%0d_irq", i), {15'h0, irq}, {15'h0, vt[i].irq});
            rd(1'b1, vt[i].st, $sformatf("v%0d_status", i));
            rd(1'b0, vt[i].dat, $sformatf("v%0d_data", i));
            rd(1'b1, 16'h0002, $sformatf("v%0d_status_clr", i));
            chk($sformatf("v%0d_irq_clr", i), {15'h0, irq}, 16'h0000);
        end

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(1'b1, 16'h0007, "ovr_status");
        rd(1'b0, 16'h0011, "ovr_data");
        rd(1'b1, 16'h0002, "ovr_status_clr");

        rxd = 1'b0;
        repeat (2) tick();
        rxd = 1'b1;
        repeat (20) tick();
        rd(1'b1, 16'h0002, "glitch_status");
        chk("glitch_irq", {15'h0, irq}, 16'h0000);

        send_rx(8'h3C, 1'b1);
        fork
            send_rx(8'h44, 1'b1);
            begin
                repeat (71) tick();
                bus(1'b0, 1'b0, 1'b0, 16'h0000, 12);
            end
        join
        chk("long_cs_dout", data_out, 16'h0044);
        rd(1'b1, 16'h0003, "long_cs_status");
        rd(1'b0, 16'h0044, "long_cs_data");
        rd(1'b1, 16'h0002, "long_cs_status_clr");

        bus(1'b1, 1'b0, 1'b1, 16'h0000, 1);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        chk("midrst_txd", {15'h0, txd}, 16'h0001);
        chk("midrst_dout", data_out, 16'h0000);
        reset = 1'b0;
        tick();
        idle_check(40, "midrst_tx_idle");
        rd(1'b1, 16'h0002, "midrst_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
